// File: rtl/ba20x_pkg.sv
// Shared definitions for the UART TX path: FSM state encodings, data width and baud divider helper.
package ba20x_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    UART_S_IDLE   = 3'd0,
    UART_S_START  = 3'd1,
    UART_S_DATA   = 3'd2,
    UART_S_STOP   = 3'd3,
    UART_S_PARITY = 3'd4
  } uart_state_e;

  // Clock cycles per bit; truncating division, caller guarantees a result >= 2.
  function automatic int uart_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage : ba20x_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop handshake, full/empty flags and occupancy level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  // Full is judged on current pointers only, so a same-cycle pop never frees room for a push.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule : sync_fifo

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 LSB-first serialiser on a registered TXD pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo
  import ba20x_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_i_valid,
  input  logic [UART_DATA_W-1:0]        uart_i_data,
  output logic                          uart_o_ready,
  output logic                          uart_o_txd,
  output logic                          uart_o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   uart_o_level
);

  localparam int DIV   = uart_baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  uart_state_e            state_q;
  logic [CNT_W-1:0]       baud_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  logic                   fifo_full, fifo_empty, fifo_pop, baud_last;
  logic [UART_DATA_W-1:0] fifo_data;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (uart_i_valid),
    .data_i  (uart_i_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (uart_o_level)
  );

  assign baud_last    = (baud_cnt_q == CNT_W'(DIV - 1));
  // Pop from IDLE, or on the final stop-bit cycle so the next start bit follows with no gap.
  assign fifo_pop     = !fifo_empty &&
                        ((state_q == UART_S_IDLE) || ((state_q == UART_S_STOP) && baud_last));
  assign uart_o_ready = !fifo_full;
  assign uart_o_busy  = (state_q != UART_S_IDLE) || !fifo_empty;
  assign uart_o_txd   = txd_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      UART_S_START:  txd_d = 1'b0;
      UART_S_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      UART_S_PARITY: txd_d = parity_q;
`endif
      default:       txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UART_S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      txd_q <= txd_d;
      case (state_q)
        UART_S_IDLE: begin
          if (!fifo_empty) begin
            shift_q    <= fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^fifo_data;
`endif
            baud_cnt_q <= '0;
            state_q    <= UART_S_START;
          end
        end
        UART_S_START: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= UART_S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        UART_S_DATA: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= UART_S_PARITY;
`else
              state_q <= UART_S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        UART_S_PARITY: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            state_q    <= UART_S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
`endif
        UART_S_STOP: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (!fifo_empty) begin
              shift_q  <= fifo_data;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^fifo_data;
`endif
              state_q  <= UART_S_START;
            end else begin
              state_q  <= UART_S_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          baud_cnt_q <= '0;
          state_q    <= UART_S_IDLE;
        end
      endcase
    end
  end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic against a line-level model.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_i_valid;
  logic [7:0] uart_i_data;
  logic       uart_o_ready;
  logic       uart_o_txd;
  logic       uart_o_busy;
  logic [3:0] uart_o_level;

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_i_valid (uart_i_valid),
    .uart_i_data  (uart_i_data),
    .uart_o_ready (uart_o_ready),
    .uart_o_txd   (uart_o_txd),
    .uart_o_busy  (uart_o_busy),
    .uart_o_level (uart_o_level)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes, future line samples (one per cycle) and cycles left in the frame.
  logic [7:0] fifo_m[$];
  bit         line_m[$];
  int         tx_left;
  bit         exp_txd;
  int         passed = 0;
  int         total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    fifo_m.delete();
    line_m.delete();
    tx_left = 0;
    exp_txd = 1'b1;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d);
    bit         pop_now, push_ok;
    logic [7:0] b;
    pop_now = (tx_left <= 1) && (fifo_m.size() > 0);
    push_ok = v && (fifo_m.size() < DEPTH);
    exp_txd = (line_m.size() > 0) ? line_m.pop_front() : 1'b1;
    if (pop_now) begin
      b = fifo_m.pop_front();
      for (int k = 0; k < DIV; k++) line_m.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < DIV; k++) line_m.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      for (int k = 0; k < DIV; k++) line_m.push_back(^b);
`endif
      for (int k = 0; k < DIV; k++) line_m.push_back(1'b1);
      tx_left = FRAME;
    end else if (tx_left > 0) begin
      tx_left--;
    end
    if (push_ok) fifo_m.push_back(d);
  endtask

  // One clock: drive inputs, check ready before the edge, advance model, check outputs after it.
  task automatic cycle(input bit v, input logic [7:0] d);
    uart_i_valid = v;
    uart_i_data  = d;
    check("ready", {31'd0, uart_o_ready}, {31'd0, fifo_m.size() < DEPTH});
    @(posedge clk);
    model_edge(v, d);
    #1;
    check("txd",   {31'd0, uart_o_txd},  {31'd0, exp_txd});
    check("level", {28'd0, uart_o_level}, fifo_m.size());
    check("busy",  {31'd0, uart_o_busy}, {31'd0, (tx_left > 0) || (fifo_m.size() > 0)});
    uart_i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < (DEPTH + 2) * FRAME && (tx_left > 0 || fifo_m.size() > 0); i++)
      cycle(1'b0, 8'h00);
    repeat (3) cycle(1'b0, 8'h00);
  endtask

  initial begin
    rst          = 1'b1;
    uart_i_valid = 1'b0;
    uart_i_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_txd",   {31'd0, uart_o_txd},   32'd1);
    check("rst_busy",  {31'd0, uart_o_busy},  32'd0);
    check("rst_level", {28'd0, uart_o_level}, 32'd0);
    check("rst_ready", {31'd0, uart_o_ready}, 32'd1);
    rst = 1'b0;

    // Single byte 0xA5: start low two cycles after push, LSB-first data, stop high.
    cycle(1'b1, 8'hA5);
    drain();

    // Back-to-back 0x00, 0xFF: second start bit directly follows the first stop bit.
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    drain();

    // Overfill while the first frame is in flight: eight queue, extra pushes are dropped.
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 8'(8'h10 + i));
    check("full_level", {28'd0, uart_o_level}, DEPTH);
    check("full_ready", {31'd0, uart_o_ready}, 32'd0);
    drain();

    // Push coinciding with the end-of-frame pop at level 3 leaves level at 3.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i));
    for (int i = 0; i < FRAME && tx_left > 1; i++) cycle(1'b0, 8'h00);
    check("pre_swap_level", {28'd0, uart_o_level}, 32'd3);
    cycle(1'b1, 8'h3C);
    check("swap_level", {28'd0, uart_o_level}, 32'd3);
    drain();

`ifdef UART_TX_PARITY_EN
    cycle(1'b1, 8'h07);
    drain();
`endif

    // Reset during data bit 4 of 0x0F (a low bit): txd returns high immediately.
    cycle(1'b1, 8'h0F);
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'hAA);
    repeat (54) cycle(1'b0, 8'h00);
    check("pre_rst_txd", {31'd0, uart_o_txd}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_txd",   {31'd0, uart_o_txd},   32'd1);
    check("mid_rst_level", {28'd0, uart_o_level}, 32'd0);
    check("mid_rst_ready", {31'd0, uart_o_ready}, 32'd1);
    check("mid_rst_busy",  {31'd0, uart_o_busy},  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (30) cycle(1'b0, 8'h00);

    // Random traffic: sparse then bursty so the full/drop path is exercised.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 99) < 6, 8'($urandom));
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 99) < 50, 8'($urandom));
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_uart_tx_fifo
